// File: rtl/rotary_quad_decoder_pkg.sv
// Shared definitions for the rotary encoder front end: quadrature FSM states
// and the A/B rest code seen at every detent.
package rotary_quad_decoder_pkg;

    localparam logic [1:0] AB_REST = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CW1  = 3'd1,
        ST_CW2  = 3'd2,
        ST_CW3  = 3'd3,
        ST_CCW1 = 3'd4,
        ST_CCW2 = 3'd5,
        ST_CCW3 = 3'd6,
        ST_WAIT = 3'd7
    } quad_state_t;

endpackage

// File: rtl/rotary_quad_decoder_debounce_filter.sv
// Two-flop synchroniser followed by a stable-run counter; the filtered
// output only follows the pin after DEBOUNCE_CYCLES consecutive differing cycles.
module debounce_filter #(
    parameter int DEBOUNCE_CYCLES = 4096,
    parameter int CNT_W           = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_raw,
    input  logic rst_val,
    output logic q
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= rst_val;
            sync_2 <= rst_val;
            q      <= rst_val;
            cnt    <= '0;
        end else begin
            sync_1 <= d_raw;
            sync_2 <= sync_1;
            // Any cycle where the pin agrees with the filtered value restarts the run.
            if (sync_2 == q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                q   <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rotary_quad_decoder.sv
// Rotary encoder front end: debounced A/B/push pins, full-detent quadrature
// decoding and single-cycle cw / ccw / btn / err pulses.
module rotary_quad_decoder
    import rotary_quad_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4096,
    parameter int CNT_W           = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rot_a,
    input  logic rot_b,
    input  logic rot_push,
    output logic cw,
    output logic ccw,
    output logic btn,
    output logic err
);

    logic [1:0]  rst_pipe;
    logic        rst_sync_n;
    logic        a_deb;
    logic        b_deb;
    logic        push_deb;
    logic        push_prev;
    logic [1:0]  ab;
    logic [1:0]  ab_prev;
    quad_state_t state;
    quad_state_t state_next;
    logic        cw_next;
    logic        ccw_next;
    logic        err_next;

    // Reset asserts immediately but releases in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_pipe[1];

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_a (
        .clk(clk), .rst_n(rst_sync_n), .d_raw(rot_a), .rst_val(AB_REST[1]), .q(a_deb)
    );

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_b (
        .clk(clk), .rst_n(rst_sync_n), .d_raw(rot_b), .rst_val(AB_REST[0]), .q(b_deb)
    );

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_push (
        .clk(clk), .rst_n(rst_sync_n), .d_raw(rot_push), .rst_val(1'b0), .q(push_deb)
    );

    assign ab = {a_deb, b_deb};

    // The FSM only moves on a debounced A/B change; a two-bit jump is illegal
    // and parks in WAIT until the encoder is back on a detent.
    always_comb begin
        state_next = state;
        cw_next    = 1'b0;
        ccw_next   = 1'b0;
        err_next   = 1'b0;
        if (ab != ab_prev) begin
            case (state)
                ST_IDLE: begin
                    if (ab == 2'b01)      state_next = ST_CW1;
                    else if (ab == 2'b10) state_next = ST_CCW1;
                    else begin state_next = ST_WAIT; err_next = 1'b1; end
                end
                ST_CW1: begin
                    if (ab == 2'b00)         state_next = ST_CW2;
                    else if (ab == AB_REST)  state_next = ST_IDLE;
                    else begin state_next = ST_WAIT; err_next = 1'b1; end
                end
                ST_CW2: begin
                    if (ab == 2'b10)      state_next = ST_CW3;
                    else if (ab == 2'b01) state_next = ST_CW1;
                    else begin state_next = ST_WAIT; err_next = 1'b1; end
                end
                ST_CW3: begin
                    if (ab == AB_REST) begin state_next = ST_IDLE; cw_next = 1'b1; end
                    else if (ab == 2'b00)    state_next = ST_CW2;
                    else begin state_next = ST_WAIT; err_next = 1'b1; end
                end
                ST_CCW1: begin
                    if (ab == 2'b00)         state_next = ST_CCW2;
                    else if (ab == AB_REST)  state_next = ST_IDLE;
                    else begin state_next = ST_WAIT; err_next = 1'b1; end
                end
                ST_CCW2: begin
                    if (ab == 2'b01)      state_next = ST_CCW3;
                    else if (ab == 2'b10) state_next = ST_CCW1;
                    else begin state_next = ST_WAIT; err_next = 1'b1; end
                end
                ST_CCW3: begin
                    if (ab == AB_REST) begin state_next = ST_IDLE; ccw_next = 1'b1; end
                    else if (ab == 2'b00)    state_next = ST_CCW2;
                    else begin state_next = ST_WAIT; err_next = 1'b1; end
                end
                ST_WAIT: begin
                    if (ab == AB_REST) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state     <= ST_IDLE;
            ab_prev   <= AB_REST;
            push_prev <= 1'b0;
            cw        <= 1'b0;
            ccw       <= 1'b0;
            err       <= 1'b0;
            btn       <= 1'b0;
        end else begin
            state     <= state_next;
            ab_prev   <= ab;
            push_prev <= push_deb;
            cw        <= cw_next;
            ccw       <= ccw_next;
            err       <= err_next;
            btn       <= push_deb & ~push_prev;
        end
    end

endmodule
